// File: rtl/tdm_demux.sv
// TDM demultiplexer: collects N serial slot bits into a shadow frame and
// publishes the complete frame on Y once slot N-1 has been written.
// A frame_start on a mid-frame sample aborts the partial frame (frame_err)
// and restarts collection from slot 0 with that sample.
module tdm_demux #(
    parameter int N = 4,
    parameter int P = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         din,
    input  logic         din_valid,
    input  logic         frame_start,
    output logic [N-1:0] Y,
    output logic         frame_valid,
    output logic         frame_err,
    output logic [P-1:0] slot,
    output logic         busy
);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    localparam logic [P-1:0] LAST_SLOT = P'(N - 1);
    localparam logic [P-1:0] SLOT_ONE  = P'(1);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [P-1:0]   r_slot;
    logic [P-1:0]   w_slot_nxt;
    logic [N-1:0]   r_shadow;
    logic [N-1:0]   w_shadow_nxt;
    logic [N-1:0]   w_written;
    logic [N-1:0]   r_y;
    logic [N-1:0]   w_y_nxt;
    logic           r_frame_valid;
    logic           w_frame_valid_nxt;
    logic           r_frame_err;
    logic           w_frame_err_nxt;
    logic           r_busy;

    // Shadow frame as it would look with din written into the current slot;
    // this is also the value Y takes when the last slot completes a frame.
    always_comb begin
        w_written = r_shadow;
        for (int k = 0; k < N; k++) begin
            if (r_slot == P'(k)) begin
                w_written[k] = din;
            end
        end
    end

    // Next-state and next-output logic; only sample events (din_valid=1) act.
    always_comb begin
        w_state_nxt       = r_state;
        w_slot_nxt        = r_slot;
        w_shadow_nxt      = r_shadow;
        w_y_nxt           = r_y;
        w_frame_valid_nxt = 1'b0;
        w_frame_err_nxt   = 1'b0;

        if (din_valid) begin
            case (r_state)
                IDLE: begin
                    // Samples without frame_start are stray and ignored.
                    if (frame_start) begin
                        w_shadow_nxt    = r_shadow;
                        w_shadow_nxt[0] = din;
                        w_slot_nxt      = SLOT_ONE;
                        w_state_nxt     = COLLECT;
                    end
                end
                COLLECT: begin
                    if (frame_start) begin
                        // Restart: the partial frame is dropped, Y untouched.
                        w_frame_err_nxt = 1'b1;
                        w_shadow_nxt    = r_shadow;
                        w_shadow_nxt[0] = din;
                        w_slot_nxt      = SLOT_ONE;
                    end else if (r_slot == LAST_SLOT) begin
                        w_shadow_nxt      = w_written;
                        w_y_nxt           = w_written;
                        w_frame_valid_nxt = 1'b1;
                        w_slot_nxt        = '0;
                        w_state_nxt       = IDLE;
                    end else begin
                        w_shadow_nxt = w_written;
                        w_slot_nxt   = r_slot + SLOT_ONE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_slot_nxt  = '0;
                end
            endcase
        end
    end

    // State, frame storage and registered outputs; reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_slot        <= '0;
            r_shadow      <= '0;
            r_y           <= '0;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_slot        <= w_slot_nxt;
            r_shadow      <= w_shadow_nxt;
            r_y           <= w_y_nxt;
            r_frame_valid <= w_frame_valid_nxt;
            r_frame_err   <= w_frame_err_nxt;
            r_busy        <= (w_state_nxt == COLLECT);
        end
    end

    assign Y           = r_y;
    assign frame_valid = r_frame_valid;
    assign frame_err   = r_frame_err;
    assign slot        = r_slot;
    assign busy        = r_busy;

endmodule
